// File: rtl/mod_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mod_counter_pkg
// Purpose  : Shared definitions for the modulo up/down counter: direction
//            encodings and the next-count function that also reports wrap.
// Contents : DIR_UP / DIR_DOWN   - values of the 'up' input
//            count_step_t        - {next value, wrap flag}
//            next_count()        - one counting step, modulo or saturating
// Revision : 1.0 - initial release
// ============================================================================
package mod_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef struct packed {
        logic [31:0] value;
        logic        wrap;
    } count_step_t;

    // One counting step on a 32-bit view of the count. Callers narrow the
    // result back to their own width; the result always stays below
    // 'modulus', so the narrowing never loses information.
    function automatic count_step_t next_count(
        input logic [31:0] cur,
        input logic [31:0] modulus,
        input logic        dir,
        input logic        sat
    );
        count_step_t res;
        res.value = cur;
        res.wrap  = 1'b0;
        if (dir == DIR_UP) begin
            if (cur == modulus - 32'd1) begin
                if (!sat) begin
                    res.value = 32'd0;
                    res.wrap  = 1'b1;
                end
            end else begin
                res.value = cur + 32'd1;
            end
        end else begin
            if (cur == 32'd0) begin
                if (!sat) begin
                    res.value = modulus - 32'd1;
                    res.wrap  = 1'b1;
                end
            end else begin
                res.value = cur - 32'd1;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : mod_counter
// Purpose  : Loadable modulo-MODULUS up/down counter with terminal-count and
//            wrap indication.
// Params   : WIDTH   - count width in bits (1..31)
//            MODULUS - count range 0..MODULUS-1 (2..2**WIDTH)
// Ports    : clk      in  - clock, rising edge
//            rst_n    in  - asynchronous active-low reset
//            clear    in  - synchronous clear (highest priority)
//            load     in  - synchronous load of load_val (clamped)
//            load_val in  - load value
//            en       in  - count enable
//            up       in  - 1 = increment, 0 = decrement
//            sat      in  - saturate instead of wrap (MOD_COUNTER_SAT_EN only)
//            out      out - registered count
//            tc       out - combinational terminal count
//            wrap     out - registered one-cycle pulse after a wrap
// Config   : define MOD_COUNTER_SAT_EN to add the 'sat' input.
// Revision : 1.0 - initial release
// ============================================================================
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
`ifdef MOD_COUNTER_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap
);

    localparam logic [31:0]      MOD_W   = 32'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic        sat_mode;
    count_step_t step_res;
    logic [31:0] nxt_value;
    logic        nxt_wrap;

`ifdef MOD_COUNTER_SAT_EN
    assign sat_mode = sat;
`else
    assign sat_mode = 1'b0;
`endif

    assign step_res  = next_count(32'(out), MOD_W, up, sat_mode);
    assign nxt_value = step_res.value;
    assign nxt_wrap  = step_res.wrap;

    // Upper bits of the 32-bit step are always zero for an in-range count.
    generate
        if (WIDTH < 32) begin : g_hi_bits
            logic unused_hi;
            assign unused_hi = ^nxt_value[31:WIDTH];
        end
    endgenerate

    assign tc = en & (((up == DIR_UP)   && (out == MAX_VAL)) ||
                      ((up == DIR_DOWN) && (out == '0)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out  <= '0;
            wrap <= 1'b0;
        end else if (clear) begin
            out  <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            // Out-of-range loads clamp to the top of the range.
            if (32'(load_val) < MOD_W) begin
                out <= load_val;
            end else begin
                out <= MAX_VAL;
            end
            wrap <= 1'b0;
        end else if (en) begin
            out  <= WIDTH'(nxt_value);
            wrap <= nxt_wrap;
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits (>=1).
REQ-002 SHALL have parameter MODULUS, default 16, count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port clear  input  1  synchronous clear to 0.
REQ-006 SHALL have port load  input  1  synchronous parallel load.
REQ-007 SHALL have port load_val  input  WIDTH  value for load.
REQ-008 SHALL have port en  input  1  count enable.
REQ-009 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-010 SHALL have port out  output  WIDTH  registered count value.
REQ-011 SHALL have port tc  output  1  combinational terminal count: en & ((up & out==MODULUS-1) | (!up & out==0)).
REQ-012 SHALL have port wrap  output  1  registered one-cycle pulse, high in the cycle after a wrap occurred.

Function
REQ-013 SHALL apply per-edge priority: clear > load > en; with none asserted, out holds.
REQ-014 SHALL, on clear, set out=0 and wrap=0 at that edge.
REQ-015 SHALL, on load, set out=load_val when load_val < MODULUS, else out=MODULUS-1; load never pulses wrap.
REQ-016 SHALL, on en & up, set out=out+1, or out=0 with wrap=1 when out==MODULUS-1.
REQ-017 SHALL, on en & !up, set out=out-1, or out=MODULUS-1 with wrap=1 when out==0.
REQ-018 SHALL deassert wrap at every edge where no wrap occurs; back-to-back wraps (MODULUS=2) keep wrap high.
REQ-019 SHALL use a direction change of up only for the next counting edge, with no extra latency.
REQ-020 SHALL give count latency of one edge: the out change is visible after the edge at which en was sampled high.
REQ-021 SHALL never let out leave 0..MODULUS-1 under any input sequence.

Reset
REQ-022 SHALL, when rst_n=0, immediately force out=0 and wrap=0, independent of clk.
REQ-023 SHALL, on rst_n release, resume at the first rising edge where rst_n=1; a reset during counting discards the count.

Configuration
REQ-024 SHALL, with MOD_COUNTER_SAT_EN defined, add input port sat (1 bit); when sat=1, counting saturates at MODULUS-1 (up) or 0 (down), out holds, and wrap stays 0.
REQ-025 SHALL, with sat=0 or MOD_COUNTER_SAT_EN undefined, wrap per REQ-016/017; without the macro the sat port is absent.

Structure
REQ-026 SHALL place direction constants (DIR_UP=1, DIR_DOWN=0) and a function computing next count with wrap flag in package mod_counter_pkg.
REQ-027 SHALL be a single module with no sub-module; one always block for state, combinational tc.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-028 SHALL cover: reset, then en=1, up=1 for 12 edges -> out 1..9,0,1,2; wrap high only in the cycle after out 9->0; tc high while out=9.
REQ-029 SHALL cover: load_val=3 then up=0, en=1 for 5 edges -> out 2,1,0,9,8; wrap pulse after 0->9; load_val=12 -> out=9.
REQ-030 SHALL cover: clear and load both high with en=1 at out=5 -> out=0; load with en=1 -> out=load_val, not incremented.
REQ-031 SHALL cover: rst_n pulsed low mid-cycle at out=6 -> out=0 before the next edge, wrap=0.
REQ-032 SHALL cover: with MOD_COUNTER_SAT_EN and sat=1, out=8 with 3 up edges -> out 9,9,9, wrap never high; sat=0 -> out 0 with wrap pulse.
REQ-033 SHALL cover: defaults WIDTH=4, MODULUS=16, en=0 for 2 edges then en=1 -> out holds 0, then 1..15,0, wrap after 15->0.
